// File: rtl/comb_inverse_filter_pkg.sv
// Shared filter package: fixed-point constants and the fill/run state enum.
`include "constants.svh"

package comb_inverse_filter_pkg;

    localparam int FIXED_POINT_BITS = `FIXED_POINT;
    localparam int DEF_MAXLEN       = `MAX_FILTER_FIFO_LENGTH;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } filter_state_e;

endpackage

// File: rtl/comb_inverse_filter_ram.sv
// Delay-line storage: simple dual-port BRAM, synchronous read, read-before-write.
module comb_delay_ram #(
    parameter int DEPTH = 256,
    parameter int WORD  = 40
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WORD-1:0]          wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WORD-1:0]          rdata_o
);

    logic [WORD-1:0] mem_q [DEPTH];

    // Write and registered read; a same-address read returns the pre-write word.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/constants.svh
// Fixed-point format and default delay-line depth shared by the filter blocks.
`ifndef CONSTANTS_SVH
`define CONSTANTS_SVH

`define FIXED_POINT            16
`define MAX_FILTER_FIFO_LENGTH 256

`endif

// File: rtl/comb_inverse_filter.sv
// Feedforward comb y[n] = sat(x[n] - ((g*x[n-tau]) >>> FP)), inverse of the feedback comb.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   FILL  | history for the current tau incomplete; delayed term = 0
//   RUN   | at least tau samples seen since the last tau change
`include "constants.svh"

module comb_inverse_filter
    import comb_inverse_filter_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int MAXLEN = `MAX_FILTER_FIFO_LENGTH,
    parameter int MID    = 0,
    localparam int WORD  = WIDTH + `FIXED_POINT,
    localparam int AW    = $clog2(MAXLEN)
) (
    input  logic                   sample_clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    input  logic signed [WORD-1:0] in,
    input  logic [AW-1:0]          tau,
    input  logic signed [WORD-1:0] gain,
    output logic                   out_valid,
    output logic signed [WORD-1:0] out,
    output logic                   fill
);

    localparam int FP = `FIXED_POINT;
    localparam logic signed [2*WORD:0] SMAX = {{(WORD+2){1'b0}}, {(WORD-1){1'b1}}};
    localparam logic signed [2*WORD:0] SMIN = {{(WORD+2){1'b1}}, {(WORD-1){1'b0}}};

    filter_state_e           state_q, state_d, st_eff;
    logic [AW-1:0]           cnt_q, cnt_d, cnt_eff;
    logic [AW-1:0]           tau_q, tau_d, tau_c;
    logic [AW-1:0]           wp_q, wp_d, ra;
    logic                    mask;

    logic                    v0_q, v1_q, out_valid_q;
    logic signed [WORD-1:0]  x0_q, g0_q, x1_q, out_q, out_d, rd, operand;
    logic                    m0_q;
    logic signed [2*WORD-1:0] p1_q, p1_d, shifted;
    logic signed [2*WORD:0]  diff;

    // Clamp tau into 1..MAXLEN-1 and form ring addresses with modular wrap.
    always_comb begin
        tau_c = tau;
        if (tau == '0)                tau_c = AW'(1);
        else if (int'(tau) >= MAXLEN) tau_c = AW'(MAXLEN - 1);
        if (wp_q >= tau_c) ra = wp_q - tau_c;
        else               ra = wp_q + AW'(MAXLEN) - tau_c;
        wp_d = (wp_q == AW'(MAXLEN - 1)) ? '0 : wp_q + AW'(1);
    end

    // FSM next state: a tau change restarts filling on the sample that carries it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tau_d   = tau_q;
        st_eff  = state_q;
        cnt_eff = cnt_q;
        mask    = 1'b0;
        if (in_valid) begin
            tau_d = tau_c;
            if (tau_c != tau_q) begin
                st_eff  = FILL;
                cnt_eff = '0;
            end
            mask = (st_eff == FILL);
            if (st_eff == FILL) begin
                cnt_d   = cnt_eff + AW'(1);
                state_d = (cnt_eff + AW'(1) == tau_c) ? RUN : FILL;
            end else begin
                cnt_d   = cnt_eff;
                state_d = RUN;
            end
        end
    end

    // FSM state register; tau_q resets to 0, which no clamped tau equals.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FILL;
            cnt_q   <= '0;
            tau_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tau_q   <= tau_d;
        end
    end

    comb_delay_ram #(
        .DEPTH (MAXLEN),
        .WORD  (WORD)
    ) u_ram (
        .clk_i   (sample_clk),
        .we_i    (in_valid),
        .waddr_i (wp_q),
        .wdata_i (in),
        .re_i    (in_valid),
        .raddr_i (ra),
        .rdata_o (rd)
    );

    // Multiply operand selection, then subtract/shift/saturate for the last stage.
    always_comb begin
        operand = m0_q ? '0 : $signed(rd);
        p1_d    = g0_q * operand;
        shifted = p1_q >>> FP;
        diff    = $signed({{(WORD+1){x1_q[WORD-1]}}, x1_q})
                - $signed({shifted[2*WORD-1], shifted});
        if (diff > SMAX)      out_d = {1'b0, {(WORD-1){1'b1}}};
        else if (diff < SMIN) out_d = {1'b1, {(WORD-1){1'b0}}};
        else                  out_d = diff[WORD-1:0];
    end

    // Three-stage pipeline; valids shift every cycle, data loads only when qualified.
    always_ff @(posedge sample_clk or negedge rstn) begin
        if (!rstn) begin
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            x0_q        <= '0;
            g0_q        <= '0;
            m0_q        <= 1'b0;
            x1_q        <= '0;
            p1_q        <= '0;
            out_q       <= '0;
            wp_q        <= '0;
        end else begin
            v0_q        <= in_valid;
            v1_q        <= v0_q;
            out_valid_q <= v1_q;
            if (in_valid) begin
                x0_q <= in;
                g0_q <= gain;
                m0_q <= mask;
                wp_q <= wp_d;
            end
            if (v0_q) begin
                x1_q <= x0_q;
                p1_q <= p1_d;
            end
            if (v1_q) out_q <= out_d;
        end
    end

    // Flag an unknown sample being accepted.
    always @(posedge sample_clk) begin
        if (rstn && in_valid)
            assert (!$isunknown(in))
            else $error("comb_inverse_filter[%0d]: unknown value on in", MID);
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign fill      = (state_q == FILL);

endmodule

// File: tb/tb_comb_inverse_filter.sv
// Self-checking bench for comb_inverse_filter with a sample-level reference model.
module tb_comb_inverse_filter;
    import comb_inverse_filter_pkg::*;

    localparam int WIDTH = 24;
    localparam int FP    = FIXED_POINT_BITS;
    localparam int W     = WIDTH + FP;
    localparam int ML    = 120;
    localparam int TW    = $clog2(ML);

    typedef logic signed [W-1:0]     word_t;
    typedef logic signed [2*W+1:0]   wide_t;

    localparam word_t WMAX = {1'b0, {(W-1){1'b1}}};
    localparam word_t WMIN = {1'b1, {(W-1){1'b0}}};

    logic          sample_clk = 1'b0;
    logic          rstn       = 1'b0;
    logic          in_valid   = 1'b0;
    word_t         in_s       = '0;
    word_t         gain       = '0;
    logic [TW-1:0] tau        = '0;
    logic          out_valid;
    word_t         out_s;
    logic          fill;

    always #5 sample_clk = ~sample_clk;

    comb_inverse_filter #(
        .WIDTH  (WIDTH),
        .MAXLEN (ML),
        .MID    (3)
    ) dut (
        .sample_clk (sample_clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in         (in_s),
        .tau        (tau),
        .gain       (gain),
        .out_valid  (out_valid),
        .out        (out_s),
        .fill       (fill)
    );

    int    n_chk  = 0;
    int    n_fail = 0;
    word_t hist[$];
    word_t exp_q[$];
    word_t comb_hist[$];
    int    prev_t   = -1;
    int    run_len  = 0;
    logic  exp_fill = 1'b1;
    logic [2:0] vsh = '0;

    task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
        n_chk++;
        assert (o === e)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    function automatic word_t sat_w(input wide_t v);
        wide_t hi, lo;
        hi = WMAX;
        lo = WMIN;
        if (v > hi) return WMAX;
        if (v < lo) return WMIN;
        return v[W-1:0];
    endfunction

    function automatic word_t ref_out(input word_t x, input word_t g, input word_t d);
        wide_t p, xw;
        p  = g * d;
        p  = p >>> FP;
        xw = x;
        return sat_w(xw - p);
    endfunction

    function automatic word_t rnd_x();
        logic signed [31:0] r;
        r = $urandom;
        r = r >>> 3;
        return word_t'(r);
    endfunction

    function automatic word_t rnd_g();
        logic [31:0] r;
        r = $urandom;
        return word_t'($signed(r[16:0]));
    endfunction

    // Reference: one accepted sample, following the fill/delay rules sample by sample.
    task automatic model_accept(input word_t x, input int t_raw, input word_t g,
                                input bit ov, input word_t ov_val);
        int    t;
        word_t d;
        t = (t_raw == 0) ? 1 : ((t_raw >= ML) ? ML - 1 : t_raw);
        if (t != prev_t) run_len = 0;
        prev_t = t;
        if (run_len < t) d = '0;
        else             d = hist[hist.size() - t];
        exp_q.push_back(ov ? ov_val : ref_out(x, g, d));
        hist.push_back(x);
        run_len++;
        exp_fill = (run_len < t);
    endtask

    task automatic step(input bit v, input word_t x, input int t, input word_t g,
                        input bit ov = 1'b0, input word_t ov_val = '0);
        @(posedge sample_clk);
        #1;
        chk("fill", fill, exp_fill);
        in_valid = v;
        in_s     = x;
        tau      = TW'(t);
        gain     = g;
        if (v) model_accept(x, int'(tau), g, ov, ov_val);
    endtask

    task automatic do_reset();
        @(posedge sample_clk);
        #1;
        rstn     = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out", out_s, '0);
        chk("rst_out_valid", out_valid, '0);
        chk("rst_fill", fill, 1);
        hist.delete();
        exp_q.delete();
        prev_t   = -1;
        run_len  = 0;
        exp_fill = 1'b1;
        repeat (2) @(posedge sample_clk);
        #1;
        rstn = 1'b1;
    endtask

    // Output monitor: valid timing against in_valid three cycles earlier, values from the model queue.
    always @(negedge sample_clk) begin
        if (!rstn) begin
            vsh = '0;
        end else begin
            chk("out_valid", out_valid, vsh[2]);
            if (out_valid) begin
                n_chk++;
                assert (exp_q.size() != 0)
                else begin
                    n_fail++;
                    $error("FAIL out_unexpected: observed out_valid with %0d pending expected %0d", exp_q.size(), 1);
                end
                if (exp_q.size() != 0) chk("out", out_s, exp_q.pop_front());
            end
            vsh = {vsh[1:0], in_valid};
        end
    end

    initial begin
        word_t g_half, g_neg1, g70, xr, yc, dd;
        wide_t acc, xw;
        g_half = word_t'(1) <<< (FP - 1);
        g_neg1 = -(word_t'(1) <<< FP);
        g70    = word_t'(45875);

        #2;
        chk("por_out", out_s, '0);
        chk("por_out_valid", out_valid, '0);
        chk("por_fill", fill, 1);
        do_reset();

        // Impulse with tau=4, g=0.5
        step(1, word_t'(1) <<< FP, 4, g_half);
        for (int i = 0; i < 9; i++) step(1, '0, 4, g_half);
        repeat (4) step(0, rnd_x(), 4, g_half);

        // Tau change 8 -> 3 while running, gain varies freely
        for (int i = 0; i < 16; i++) step(1, rnd_x(), 8, rnd_g());
        for (int i = 0; i < 10; i++) step(1, rnd_x(), 3, rnd_g());

        // Saturation: tau=1, g=-1.0, full-scale positive input twice
        do_reset();
        step(1, WMAX, 1, g_neg1);
        step(1, WMAX, 1, g_neg1);
        repeat (4) step(0, '0, 1, g_neg1);

        // Clamp of tau=0, then gapped stream at maximum tau across pointer wrap
        for (int i = 0; i < 5; i++) step(1, rnd_x(), 0, rnd_g());
        for (int i = 0; i < 260; i++) begin
            step(1, rnd_x(), (1 << TW) - 1, rnd_g());
            step(0, rnd_x(), $urandom_range(0, (1 << TW) - 1), rnd_g());
            step(0, rnd_x(), $urandom_range(0, (1 << TW) - 1), rnd_g());
        end

        // Reset in the middle of a dense stream
        for (int i = 0; i < 20; i++) step(1, rnd_x(), 6, rnd_g());
        do_reset();
        for (int i = 0; i < 8; i++) step(1, rnd_x(), 5, rnd_g());
        repeat (4) step(0, '0, 5, '0);

        // Inverse of the feedback comb: tau=100, g=0.7 reconstructs the original stream
        do_reset();
        comb_hist.delete();
        for (int i = 0; i < 300; i++) begin
            xr  = rnd_x();
            dd  = (comb_hist.size() >= 100) ? comb_hist[comb_hist.size() - 100] : '0;
            acc = g70 * dd;
            acc = acc >>> FP;
            xw  = xr;
            yc  = sat_w(xw + acc);
            comb_hist.push_back(yc);
            step(1, yc, 100, g70, 1'b1, xr);
        end

        repeat (6) step(0, '0, 100, g70);
        chk("drained", W'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
